// File: rtl/fifo_ram_multi_if.sv
// rtl/fifo_ram_multi_if.sv - handshake, random-access and status bundle for fifo_ram_multi
interface fifo_ram_multi_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int N_ENQ         = 2,
  parameter int N_DEQ         = 2,
  parameter int N_READ_PORTS  = 2,
  parameter int N_WRITE_PORTS = 2
);
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CTR_WIDTH = PTR_WIDTH + 1;

  logic                                        flush;
  logic [N_ENQ-1:0]                            enq_ready;
  logic [N_ENQ-1:0]                            enq_valid;
  logic [N_ENQ-1:0][DATA_WIDTH-1:0]            enq_data;
  logic [N_DEQ-1:0]                            deq_valid;
  logic [N_DEQ-1:0]                            deq_ready;
  logic [N_DEQ-1:0][DATA_WIDTH-1:0]            deq_data;
  logic [N_READ_PORTS-1:0][PTR_WIDTH-1:0]      rd_addr;
  logic [N_READ_PORTS-1:0][DATA_WIDTH-1:0]     rd_data;
  logic [N_WRITE_PORTS-1:0]                    wr_en;
  logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]     wr_addr;
  logic [N_WRITE_PORTS-1:0][DATA_WIDTH-1:0]    wr_data;
  logic [PTR_WIDTH-1:0]                        enq_ptr;
  logic [PTR_WIDTH-1:0]                        deq_ptr;
  logic [CTR_WIDTH-1:0]                        count;
  logic [FIFO_DEPTH-1:0]                       entry_valid;

  modport master (
    output flush, enq_valid, enq_data, deq_ready, rd_addr, wr_en, wr_addr, wr_data,
    input  enq_ready, deq_valid, deq_data, rd_data, enq_ptr, deq_ptr, count, entry_valid
  );

  modport slave (
    input  flush, enq_valid, enq_data, deq_ready, rd_addr, wr_en, wr_addr, wr_data,
    output enq_ready, deq_valid, deq_data, rd_data, enq_ptr, deq_ptr, count, entry_valid
  );
endinterface

// File: rtl/fifo_ram_multi.sv
// rtl/fifo_ram_multi.sv - multi-lane circular FIFO over a RAM with random read/write ports
module fifo_ram_multi #(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int N_ENQ         = 2,
  parameter int N_DEQ         = 2,
  parameter int N_READ_PORTS  = 2,
  parameter int N_WRITE_PORTS = 2
) (
  input  logic                  clk,
  input  logic                  rst_aL,
  fifo_ram_multi_if.slave       bus
);
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CTR_WIDTH = PTR_WIDTH + 1;

  logic [CTR_WIDTH-1:0]  r_enq_ctr;
  logic [CTR_WIDTH-1:0]  r_deq_ctr;
  logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];

  logic [CTR_WIDTH-1:0]  w_count;
  logic [CTR_WIDTH-1:0]  w_free;
  logic [PTR_WIDTH-1:0]  w_enq_ptr;
  logic [PTR_WIDTH-1:0]  w_deq_ptr;
  logic [N_ENQ-1:0]      w_enq_ready;
  logic [N_DEQ-1:0]      w_deq_valid;
  logic [CTR_WIDTH-1:0]  w_n_enq;
  logic [CTR_WIDTH-1:0]  w_n_deq;
  logic                  w_enq_run;
  logic                  w_deq_run;
  logic [N_ENQ-1:0]      w_enq_we;
  logic [PTR_WIDTH-1:0]  w_enq_slot [N_ENQ];

  // The extra counter bit separates full (count == DEPTH) from empty.
  assign w_count   = r_enq_ctr - r_deq_ctr;
  assign w_free    = CTR_WIDTH'(FIFO_DEPTH) - w_count;
  assign w_enq_ptr = r_enq_ctr[PTR_WIDTH-1:0];
  assign w_deq_ptr = r_deq_ctr[PTR_WIDTH-1:0];

  genvar g;
  generate
    for (g = 0; g < N_ENQ; g++) begin : g_enq
      assign w_enq_ready[g] = (w_free >= CTR_WIDTH'(g + 1));
      assign w_enq_slot[g]  = w_enq_ptr + PTR_WIDTH'(g);
      assign w_enq_we[g]    = (CTR_WIDTH'(g) < w_n_enq) && !bus.flush;
    end
    for (g = 0; g < N_DEQ; g++) begin : g_deq
      assign w_deq_valid[g]  = (w_count >= CTR_WIDTH'(g + 1));
      assign bus.deq_data[g] = r_fifo[w_deq_ptr + PTR_WIDTH'(g)];
    end
    for (g = 0; g < N_READ_PORTS; g++) begin : g_rd
      assign bus.rd_data[g] = r_fifo[bus.rd_addr[g]];
    end
    for (g = 0; g < FIFO_DEPTH; g++) begin : g_live
      assign bus.entry_valid[g] =
        (CTR_WIDTH'(PTR_WIDTH'(PTR_WIDTH'(g) - w_deq_ptr)) < w_count);
    end
  endgenerate

  // Only the leading run of accepted lanes counts; anything after a gap is dropped.
  always_comb begin
    w_n_enq   = '0;
    w_enq_run = 1'b1;
    for (int i = 0; i < N_ENQ; i++) begin
      w_enq_run = w_enq_run & bus.enq_valid[i] & w_enq_ready[i];
      if (w_enq_run) w_n_enq = w_n_enq + CTR_WIDTH'(1);
    end
  end

  always_comb begin
    w_n_deq   = '0;
    w_deq_run = 1'b1;
    for (int i = 0; i < N_DEQ; i++) begin
      w_deq_run = w_deq_run & w_deq_valid[i] & bus.deq_ready[i];
      if (w_deq_run) w_n_deq = w_n_deq + CTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_enq_ctr <= '0;
      r_deq_ctr <= '0;
    end else if (bus.flush) begin
      r_enq_ctr <= '0;
      r_deq_ctr <= '0;
    end else begin
      r_enq_ctr <= r_enq_ctr + w_n_enq;
      r_deq_ctr <= r_deq_ctr + w_n_deq;
    end
  end

  // Later assignments win: enqueue lanes first, then write ports in ascending order.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      for (int k = 0; k < FIFO_DEPTH; k++) r_fifo[k] <= '0;
    end else begin
      for (int i = 0; i < N_ENQ; i++) begin
        if (w_enq_we[i]) r_fifo[w_enq_slot[i]] <= bus.enq_data[i];
      end
      for (int j = 0; j < N_WRITE_PORTS; j++) begin
        if (bus.wr_en[j]) r_fifo[bus.wr_addr[j]] <= bus.wr_data[j];
      end
    end
  end

  assign bus.enq_ready = w_enq_ready;
  assign bus.deq_valid = w_deq_valid;
  assign bus.enq_ptr   = w_enq_ptr;
  assign bus.deq_ptr   = w_deq_ptr;
  assign bus.count     = w_count;
endmodule

// File: tb/tb_fifo_ram_multi.sv
// tb/tb_fifo_ram_multi.sv - directed bench for fifo_ram_multi
module tb_fifo_ram_multi;
  logic clk;
  logic rst_aL;
  int   n_tests;
  int   n_fail;

  fifo_ram_multi_if #(
    .DATA_WIDTH(32), .FIFO_DEPTH(8), .N_ENQ(2), .N_DEQ(2),
    .N_READ_PORTS(2), .N_WRITE_PORTS(2)
  ) u_if ();

  fifo_ram_multi #(
    .DATA_WIDTH(32), .FIFO_DEPTH(8), .N_ENQ(2), .N_DEQ(2),
    .N_READ_PORTS(2), .N_WRITE_PORTS(2)
  ) dut (
    .clk    (clk),
    .rst_aL (rst_aL),
    .bus    (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    u_if.flush     = 1'b0;
    u_if.enq_valid = '0;
    u_if.enq_data  = '0;
    u_if.deq_ready = '0;
    u_if.wr_en     = '0;
    u_if.wr_addr   = '0;
    u_if.wr_data   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [1:0] dr);
    u_if.enq_valid   = v;
    u_if.enq_data[0] = d0;
    u_if.enq_data[1] = d1;
    u_if.deq_ready   = dr;
    step();
    idle();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    u_if.rd_addr = '0;
    rst_aL = 1'b1;
    #2 rst_aL = 1'b0;
    #1;
    check("rst_count", u_if.count, 0);
    check("rst_enq_ready", u_if.enq_ready, 2'b11);
    check("rst_deq_valid", u_if.deq_valid, 0);
    check("rst_entry_valid", u_if.entry_valid, 0);
    check("rst_ptrs", {u_if.enq_ptr, u_if.deq_ptr}, 0);
    @(posedge clk);
    #1 rst_aL = 1'b1;

    enq(2'b11, 32'hA0A0_0001, 32'hB0B0_0002, 2'b00);
    check("two_count", u_if.count, 2);
    check("two_deq_valid", u_if.deq_valid, 2'b11);
    check("two_deq_data0", u_if.deq_data[0], 32'hA0A0_0001);
    check("two_deq_data1", u_if.deq_data[1], 32'hB0B0_0002);
    check("two_entry_valid", u_if.entry_valid, 8'h03);
    check("two_enq_ptr", u_if.enq_ptr, 2);

    enq(2'b11, 32'h102, 32'h103, 2'b00);
    enq(2'b11, 32'h104, 32'h105, 2'b00);
    enq(2'b01, 32'h106, 32'h0, 2'b00);
    check("seven_count", u_if.count, 7);
    check("seven_enq_ready", u_if.enq_ready, 2'b01);
    enq(2'b11, 32'h107, 32'h999, 2'b00);
    check("full_count", u_if.count, 8);
    check("full_enq_ready", u_if.enq_ready, 2'b00);
    check("full_entry_valid", u_if.entry_valid, 8'hFF);
    check("full_enq_ptr", u_if.enq_ptr, 0);
    u_if.rd_addr[0] = 3'd7;
    u_if.rd_addr[1] = 3'd0;
    #1;
    check("full_rd7", u_if.rd_data[0], 32'h107);
    check("full_rd0_lane1_ignored", u_if.rd_data[1], 32'hA0A0_0001);

    enq(2'b00, 0, 0, 2'b10);
    check("deq_gap_count", u_if.count, 8);
    enq(2'b00, 0, 0, 2'b11);
    check("deq2_count", u_if.count, 6);
    check("deq2_deq_ptr", u_if.deq_ptr, 2);
    check("deq2_data0", u_if.deq_data[0], 32'h102);
    check("deq2_data1", u_if.deq_data[1], 32'h103);
    enq(2'b10, 32'h777, 32'h778, 2'b00);
    check("enq_gap_count", u_if.count, 6);
    check("enq_gap_ptr", u_if.enq_ptr, 0);

    u_if.flush = 1'b1;
    step();
    idle();
    check("flush1_count", u_if.count, 0);
    enq(2'b11, 32'h200, 32'h201, 2'b00);
    enq(2'b11, 32'h202, 32'h203, 2'b11);
    enq(2'b11, 32'h204, 32'h205, 2'b11);
    enq(2'b00, 0, 0, 2'b11);
    check("wrap_pre_count", u_if.count, 0);
    check("wrap_pre_ptrs", {u_if.enq_ptr, u_if.deq_ptr}, {3'd6, 3'd6});
    enq(2'b11, 32'h206, 32'h207, 2'b00);
    enq(2'b11, 32'h300, 32'h301, 2'b11);
    check("wrap_count", u_if.count, 2);
    check("wrap_deq_ptr", u_if.deq_ptr, 0);
    check("wrap_enq_ptr", u_if.enq_ptr, 2);
    check("wrap_entry_valid", u_if.entry_valid, 8'h03);
    check("wrap_deq_data0", u_if.deq_data[0], 32'h300);
    check("wrap_deq_data1", u_if.deq_data[1], 32'h301);
    u_if.rd_addr[0] = 3'd6;
    u_if.rd_addr[1] = 3'd7;
    #1;
    check("wrap_rd6", u_if.rd_data[0], 32'h206);
    check("wrap_rd7", u_if.rd_data[1], 32'h207);

    enq(2'b01, 32'h302, 32'h0, 2'b00);
    check("prio_pre_enq_ptr", u_if.enq_ptr, 3);
    u_if.enq_valid   = 2'b01;
    u_if.enq_data[0] = 32'h11;
    u_if.wr_en       = 2'b11;
    u_if.wr_addr[0]  = 3'd3;
    u_if.wr_addr[1]  = 3'd3;
    u_if.wr_data[0]  = 32'h22;
    u_if.wr_data[1]  = 32'h33;
    u_if.rd_addr[0]  = 3'd3;
    #1;
    check("prio_rd_old", u_if.rd_data[0], 32'h203);
    step();
    idle();
    check("prio_rd_new", u_if.rd_data[0], 32'h33);
    check("prio_count", u_if.count, 4);

    enq(2'b01, 32'h304, 32'h0, 2'b00);
    check("pre_flush_count", u_if.count, 5);
    u_if.flush       = 1'b1;
    u_if.enq_valid   = 2'b11;
    u_if.enq_data[0] = 32'hDEAD0;
    u_if.enq_data[1] = 32'hDEAD1;
    u_if.deq_ready   = 2'b11;
    u_if.wr_en       = 2'b01;
    u_if.wr_addr[0]  = 3'd6;
    u_if.wr_data[0]  = 32'h66;
    step();
    idle();
    u_if.rd_addr[0] = 3'd5;
    u_if.rd_addr[1] = 3'd6;
    #1;
    check("flush_count", u_if.count, 0);
    check("flush_ptrs", {u_if.enq_ptr, u_if.deq_ptr}, 0);
    check("flush_deq_valid", u_if.deq_valid, 0);
    check("flush_entry_valid", u_if.entry_valid, 0);
    check("flush_enq_dropped", u_if.rd_data[0], 32'h205);
    check("flush_wr_applied", u_if.rd_data[1], 32'h66);

    enq(2'b11, 32'h400, 32'h401, 2'b00);
    check("arst_pre_count", u_if.count, 2);
    u_if.rd_addr[0] = 3'd0;
    #2 rst_aL = 1'b0;
    #1;
    check("arst_count", u_if.count, 0);
    check("arst_deq_valid", u_if.deq_valid, 0);
    check("arst_enq_ready", u_if.enq_ready, 2'b11);
    check("arst_entry_cleared", u_if.rd_data[0], 0);
    #1 rst_aL = 1'b1;
    enq(2'b11, 32'h500, 32'h501, 2'b00);
    check("post_arst_count", u_if.count, 2);
    check("post_arst_data0", u_if.deq_data[0], 32'h500);
    check("post_arst_enq_ptr", u_if.enq_ptr, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_ram_multi.md
Name: fifo_ram_multi

Overview:
- Superscalar circular FIFO backed by a randomly addressable RAM.
- Accepts up to N_ENQ entries and retires up to N_DEQ entries per cycle, in order.
- Exposes random read/write ports for partial in-place updates of queued entries, e.g. ROB/LSQ-style completion writes.
- Adds a synchronous flush and a per-entry occupancy mask.

Parameters:
- DATA_WIDTH, 32, width of one entry
- FIFO_DEPTH, 8, number of entries; must be a power of 2, >= max(N_ENQ, N_DEQ)
- N_ENQ, 2, enqueue lanes per cycle
- N_DEQ, 2, dequeue lanes per cycle
- N_READ_PORTS, 2, random-access read ports
- N_WRITE_PORTS, 2, random-access write ports
- PTR_WIDTH, clog2(FIFO_DEPTH), derived; CTR_WIDTH = PTR_WIDTH+1, derived

Ports:
- clk  in  1  clock
- rst_aL  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous empty request
- enq_ready  out  N_ENQ  lane i ready iff free entries >= i+1
- enq_valid  in  N_ENQ  per-lane enqueue request
- enq_data  in  N_ENQ x DATA_WIDTH  lane payloads
- deq_valid  out  N_DEQ  lane i valid iff count >= i+1
- deq_ready  in  N_DEQ  per-lane consumer accept
- deq_data  out  N_DEQ x DATA_WIDTH  fifo[deq_ptr+i], combinational
- rd_addr  in  N_READ_PORTS x PTR_WIDTH  random read address
- rd_data  out  N_READ_PORTS x DATA_WIDTH  fifo[rd_addr], combinational
- wr_en  in  N_WRITE_PORTS  random write enables
- wr_addr  in  N_WRITE_PORTS x PTR_WIDTH  random write address
- wr_data  in  N_WRITE_PORTS x DATA_WIDTH  random write data
- enq_ptr  out  PTR_WIDTH  current tail slot
- deq_ptr  out  PTR_WIDTH  current head slot
- count  out  CTR_WIDTH  occupancy 0..FIFO_DEPTH
- entry_valid  out  FIFO_DEPTH  bit k set iff slot k holds a live entry

Behaviour:
- State:
  - enq_ctr, deq_ctr, CTR_WIDTH each, wrap mod 2^CTR_WIDTH.
  - fifo array FIFO_DEPTH x DATA_WIDTH.
  - count = enq_ctr - deq_ctr (mod). Full iff count == FIFO_DEPTH; empty iff count == 0.
- Reset (rst_aL low, async): counters 0, all entries 0. Resulting outputs:
  - count=0, enq_ready all 1 (FIFO_DEPTH >= N_ENQ)
  - deq_valid all 0, entry_valid 0, pointers 0
- enq_ready and deq_valid derive from registered count only. No same-cycle enq/deq bypass.
- Enqueue:
  - n_enq = length of the leading run of lanes 0..k with enq_valid & enq_ready.
  - A lane after the first unaccepted lane is ignored, even if valid.
  - Lane i (i < n_enq) writes fifo[enq_ptr+i mod DEPTH].
- Dequeue: n_deq = length of the leading run of lanes with deq_valid & deq_ready. Same prefix rule as enqueue.
- Next state: enq_ctr += n_enq; deq_ctr += n_deq. Enq and deq proceed simultaneously, including when full or empty, subject to registered ready/valid.
- Write priority within a cycle:
  - Enqueue writes first.
  - Then write ports in ascending index; a higher index overrides.
  - A write port overrides an enqueue to the same slot.
  - Writes to non-live slots are permitted and take effect.
- Reads: all reads return pre-edge contents. There is no write-to-read forwarding.
- flush=1:
  - Both counters go to 0 next cycle; enq/deq handshakes that cycle are discarded.
  - Entry contents are not cleared; write ports still apply.
  - Flush has priority over enq/deq; reset has priority over flush.
- entry_valid[k] = ((k - deq_ptr) mod DEPTH) < count.
- Wrap-around: pointer arithmetic is mod DEPTH; the counter MSB distinguishes full from empty.
- Reset asserted mid-operation: state clears immediately and asynchronously. The first post-release edge behaves as from empty.

Test Plan:
- Reset, then enq_valid=2'b11 with data A,B -> next cycle count=2, deq_valid=2'b11, deq_data[0]=A, deq_data[1]=B, entry_valid=8'h03.
- Fill to 7 entries, present enq_valid=2'b11 -> enq_ready=2'b01, only lane0 accepted, count=8, enq_ready=2'b00, entry_valid=8'hFF.
- enq_valid=2'b10 (lane0 idle) -> nothing enqueued, count unchanged; deq_ready=2'b10 on non-empty -> nothing dequeued.
- Counters at enq=6, deq=6: enq 4 entries over 2 cycles, deq 2 -> slots 6,7,0,1 written, deq_ptr=0, count=2, entry_valid=8'h03 (wrap-around).
- In one cycle, enq lane0 to slot 3 (data 0x11), wr_en=2'b11 both to slot 3 (0x22, 0x33) -> fifo[3]=0x33; rd_addr=3 returns old value that cycle and 0x33 next.
- count=5 with flush=1, enq_valid=2'b11, deq_ready=2'b11 -> next cycle count=0, pointers 0, deq_valid=0. Assert rst_aL low mid-cycle -> outputs clear without a clock edge.
